// File: rtl/axis_out_serializer.sv
// rtl/axis_out_serializer.sv - serializes processor output words into an 8-bit AXI-Stream, MSB byte first
//
// Purpose:
//   Accepts one IN_WIDTH-bit word at a time, zero-extends it to NUM_BYTES*8
//   bits and emits it as NUM_BYTES bytes, most-significant byte first, with
//   m_axis_tlast on the final byte. A new word can be taken on the same
//   cycle the last byte of the current word is accepted, so back-to-back
//   words stream without a bubble.
//
// Ports:
//   clk            in   rising-edge clock
//   arstn          in   asynchronous active-low reset
//   s_axis_tdata   in   [IN_WIDTH-1:0] word from the processor
//   s_axis_tvalid  in   word valid
//   s_axis_tready  out  word can be accepted
//   m_axis_tdata   out  [7:0] serialized byte
//   m_axis_tvalid  out  byte valid
//   m_axis_tready  in   downstream accepts byte
//   m_axis_tlast   out  final byte of the current word
//
// Build option:
//   SERIALIZER_ZERO_SKIP_EN - when defined, an all-zero input word is
//   accepted but produces no output bytes.

package processor_config;
  localparam int OUT_WIDTH = 16;
endpackage

module axis_out_serializer #(
  parameter int IN_WIDTH = processor_config::OUT_WIDTH
) (
  input  logic                clk,
  input  logic                arstn,
  input  logic [IN_WIDTH-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [7:0]          m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast
);

  localparam int NUM_BYTES = (IN_WIDTH + 7) / 8;
  localparam int EXT_WIDTH = NUM_BYTES * 8;
  localparam int CNT_WIDTH = $clog2(NUM_BYTES) + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_BYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [EXT_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [EXT_WIDTH-1:0] word_ext;
  logic                 at_last;
  logic                 in_hs;
  logic                 out_hs;
  logic                 last_hs;
  logic                 load;

  assign at_last = (state_q == SEND) && (cnt_q == LAST_CNT);
  assign in_hs   = s_axis_tvalid && s_axis_tready;
  assign out_hs  = m_axis_tvalid && m_axis_tready;
  assign last_hs = out_hs && at_last;

  // A word only enters the shift register if it will produce bytes; with
  // zero skipping enabled a zero word is consumed by the handshake alone.
`ifdef SERIALIZER_ZERO_SKIP_EN
  assign load = in_hs && (s_axis_tdata != '0);
`else
  assign load = in_hs;
`endif

  always_comb begin
    word_ext                 = '0;
    word_ext[IN_WIDTH-1:0]   = s_axis_tdata;
  end

  // State register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load) state_d = SEND;
      end
      SEND: begin
        // On the last byte, a word loaded in the same cycle keeps us in SEND
        if (last_hs) state_d = load ? SEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    m_axis_tvalid = (state_q == SEND);
    m_axis_tlast  = at_last;
    m_axis_tdata  = shreg_q[EXT_WIDTH-1 -: 8];
    s_axis_tready = arstn && ((state_q == IDLE) || (m_axis_tready && at_last));
  end

  // Shift register and byte counter
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = word_ext;
      cnt_d   = '0;
    end else if (last_hs) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (out_hs) begin
      // Next byte moves into the top byte lane
      shreg_d = shreg_q << 8;
      cnt_d   = cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axis_out_serializer.sv
// tb/tb_axis_out_serializer.sv - randomized self-checking bench for axis_out_serializer at widths 16, 12 and 8

module tb_axis_out_serializer;

  logic       clk = 1'b0;
  logic       arstn;
  logic [15:0] s_tdata  [3];
  logic        s_tvalid [3];
  logic        s_tready [3];
  logic [7:0]  m_tdata  [3];
  logic        m_tvalid [3];
  logic        m_tready [3];
  logic        m_tlast  [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Pending bytes per lane ({tlast, byte}), DUT output log, input handshake cycles
  logic [8:0] exp_q   [3][$];
  logic [8:0] log_q   [3][$];
  int         log_cyc [3][$];
  int         in_cyc  [3][$];

  logic [15:0] wq[$];
  logic        pq[$];
  logic [8:0]  eq[$];

  always #5 clk = ~clk;

  axis_out_serializer #(.IN_WIDTH(16)) dut16 (
    .clk(clk), .arstn(arstn),
    .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
    .m_axis_tlast(m_tlast[0])
  );

  axis_out_serializer #(.IN_WIDTH(12)) dut12 (
    .clk(clk), .arstn(arstn),
    .s_axis_tdata(s_tdata[1][11:0]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
    .m_axis_tlast(m_tlast[1])
  );

  axis_out_serializer #(.IN_WIDTH(8)) dut8 (
    .clk(clk), .arstn(arstn),
    .s_axis_tdata(s_tdata[2][7:0]), .s_axis_tvalid(s_tvalid[2]), .s_axis_tready(s_tready[2]),
    .m_axis_tdata(m_tdata[2]), .m_axis_tvalid(m_tvalid[2]), .m_axis_tready(m_tready[2]),
    .m_axis_tlast(m_tlast[2])
  );

  function automatic int lane_width(input int lane);
    case (lane)
      0:       return 16;
      1:       return 12;
      default: return 8;
    endcase
  endfunction

  function automatic int lane_bytes(input int lane);
    return (lane_width(lane) + 7) / 8;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Reference model and per-cycle compare, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!arstn) begin
        chk($sformatf("L%0d_rst_tvalid", i), 32'(m_tvalid[i]), 32'd0);
        chk($sformatf("L%0d_rst_tlast", i), 32'(m_tlast[i]), 32'd0);
        chk($sformatf("L%0d_rst_tdata", i), 32'(m_tdata[i]), 32'd0);
        chk($sformatf("L%0d_rst_s_tready", i), 32'(s_tready[i]), 32'd0);
        exp_q[i].delete();
      end else begin
        automatic logic ev = (exp_q[i].size() != 0);
        automatic logic er = (exp_q[i].size() == 0) || (exp_q[i].size() == 1 && m_tready[i]);
        automatic int   n  = lane_bytes(i);
        automatic logic [15:0] w = s_tdata[i] & 16'((32'h1 << lane_width(i)) - 1);
        automatic logic skip = 1'b0;
        chk($sformatf("L%0d_tvalid", i), 32'(m_tvalid[i]), 32'(ev));
        if (ev) begin
          chk($sformatf("L%0d_tdata", i), 32'(m_tdata[i]), 32'(exp_q[i][0][7:0]));
          chk($sformatf("L%0d_tlast", i), 32'(m_tlast[i]), 32'(exp_q[i][0][8]));
        end
        chk($sformatf("L%0d_s_tready", i), 32'(s_tready[i]), 32'(er));
        if (m_tvalid[i] && m_tready[i]) begin
          log_q[i].push_back({m_tlast[i], m_tdata[i]});
          log_cyc[i].push_back(cyc);
        end
        if (ev && m_tready[i]) void'(exp_q[i].pop_front());
        if (s_tvalid[i] && er) begin
          in_cyc[i].push_back(cyc);
`ifdef SERIALIZER_ZERO_SKIP_EN
          skip = (w == 16'd0);
`endif
          if (!skip) begin
            for (int k = 0; k < n; k++)
              exp_q[i].push_back({(k == n - 1), 8'(w >> ((n - 1 - k) * 8))});
          end
        end
      end
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < 3; i++) begin
      log_q[i].delete();
      log_cyc[i].delete();
      in_cyc[i].delete();
    end
  endtask

  // Offer words on one lane, ready from pattern then constant 1 or random, until drained
  task automatic run_words(input int lane, input logic [15:0] words[$], input logic pat[$], input bit rnd);
    automatic int idx = 0;
    automatic int p = 0;
    automatic int budget = 0;
    forever begin
      @(posedge clk); #1;
      if (idx >= words.size() && exp_q[lane].size() == 0) break;
      budget = budget + 1;
      if (budget > 2000) begin
        chk($sformatf("L%0d_drain_timeout", lane), 32'd1, 32'd0);
        break;
      end
      s_tvalid[lane] = (idx < words.size());
      s_tdata[lane]  = (idx < words.size()) ? words[idx] : 16'h0;
      if (p < pat.size()) m_tready[lane] = pat[p];
      else                m_tready[lane] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      p = p + 1;
      @(negedge clk);
      if (s_tvalid[lane] && s_tready[lane]) idx = idx + 1;
    end
    s_tvalid[lane] = 1'b0;
  endtask

  task automatic check_log(input int lane, input string name, input logic [8:0] exp[$]);
    chk({name, "_len"}, 32'(log_q[lane].size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < log_q[lane].size(); k++)
      chk($sformatf("%s_byte%0d", name, k), 32'(log_q[lane][k]), 32'(exp[k]));
  endtask

  task automatic check_consec(input int lane, input string name);
    for (int k = 1; k < log_cyc[lane].size(); k++)
      chk($sformatf("%s_gap%0d", name, k), 32'(log_cyc[lane][k] - log_cyc[lane][k-1]), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    arstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_tdata[i] = '0; s_tvalid[i] = 1'b0; m_tready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 arstn = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("L%0d_ready_after_reset", i), 32'(s_tready[i]), 32'd1);

    // Single word 0xA55A, ready high
    clear_logs();
    wq = {16'hA55A}; pq = {};
    run_words(0, wq, pq, 1'b0);
    eq = {9'h0A5, 9'h15A};
    check_log(0, "a55a", eq);
    check_consec(0, "a55a");
    if (log_cyc[0].size() > 0 && in_cyc[0].size() > 0)
      chk("a55a_latency", 32'(log_cyc[0][0] - in_cyc[0][0]), 32'd1);

    // Back-to-back words, no bubble
    clear_logs();
    wq = {16'h1234, 16'hBEEF};
    run_words(0, wq, pq, 1'b0);
    eq = {9'h012, 9'h134, 9'h0BE, 9'h1EF};
    check_log(0, "b2b", eq);
    check_consec(0, "b2b");

    // 12-bit word with a stall on the last byte
    clear_logs();
    wq = {16'h0ABC}; pq = {1'b1, 1'b1, 1'b0, 1'b1};
    run_words(1, wq, pq, 1'b0);
    eq = {9'h00A, 9'h1BC};
    check_log(1, "w12_stall", eq);
    if (log_cyc[1].size() == 2)
      chk("w12_stall_hold", 32'(log_cyc[1][1] - log_cyc[1][0]), 32'd2);

    // Reset in the middle of a word
    clear_logs();
    @(posedge clk); #1;
    s_tdata[0] = 16'h1234; s_tvalid[0] = 1'b1; m_tready[0] = 1'b1;
    @(posedge clk); #1 s_tvalid[0] = 1'b0;
    @(posedge clk); #1;
    arstn = 1'b0;
    #1;
    chk("midrst_tvalid", 32'(m_tvalid[0]), 32'd0);
    chk("midrst_tdata", 32'(m_tdata[0]), 32'd0);
    chk("midrst_s_tready", 32'(s_tready[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 arstn = 1'b1;
    wq = {16'h00FF}; pq = {};
    run_words(0, wq, pq, 1'b0);
    eq = {9'h012, 9'h000, 9'h1FF};
    check_log(0, "midrst", eq);

    // Zero word handling
    clear_logs();
    wq = {16'h0000, 16'h0001};
    run_words(0, wq, pq, 1'b0);
`ifdef SERIALIZER_ZERO_SKIP_EN
    eq = {9'h000, 9'h101};
`else
    eq = {9'h000, 9'h100, 9'h000, 9'h101};
`endif
    check_log(0, "zero", eq);

    // 8-bit lane: 17 random bytes, random ready
    clear_logs();
    wq = {}; eq = {};
    for (int k = 0; k < 17; k++) begin
      wq.push_back(16'($urandom_range(0, 255)));
`ifdef SERIALIZER_ZERO_SKIP_EN
      if (wq[k] != 16'd0) eq.push_back({1'b1, wq[k][7:0]});
`else
      eq.push_back({1'b1, wq[k][7:0]});
`endif
    end
    run_words(2, wq, pq, 1'b1);
    check_log(2, "w8_rand", eq);

    // 8-bit lane sustains one word per cycle
    clear_logs();
    wq = {16'h11, 16'h22, 16'h33, 16'h44};
    run_words(2, wq, pq, 1'b0);
    eq = {9'h111, 9'h122, 9'h133, 9'h144};
    check_log(2, "w8_rate", eq);
    check_consec(2, "w8_rate");
    for (int k = 1; k < in_cyc[2].size(); k++)
      chk($sformatf("w8_rate_in_gap%0d", k), 32'(in_cyc[2][k] - in_cyc[2][k-1]), 32'd1);

    // Random traffic on 16- and 12-bit lanes, including zero words
    for (int lane = 0; lane < 2; lane++) begin
      clear_logs();
      wq = {};
      for (int k = 0; k < 25; k++)
        wq.push_back(($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom()));
      run_words(lane, wq, pq, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
